as_rx_fifo: RTL and testbench

//  Receive FIFO directly downstream of the UART receiver (as_rx).

---
 rtl/as_rx_fifo.sv | 108 ++++++++++
 tb/tb_as_rx_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/as_rx_fifo.sv
// Receive FIFO between the UART receiver and the CPU bus: buffers received bytes,
// flags dropped bytes (overrun) and raises a level interrupt at a programmable fill level.
module as_rx_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             flush_i,
    input  logic             clr_ovr_i,
    input  logic [AW:0]      thresh_i,
    output logic             empty_o,
    output logic             full_o,
    output logic [AW:0]      count_o,
    output logic             overrun_o,
    output logic             irq_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;

    logic is_empty;
    logic is_full;
    logic pop_ok;
    logic push_ok;
    logic ovr_evt;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign pop_ok  = rd_i && !is_empty;
    assign push_ok = wr_i && (!is_full || pop_ok);
    assign ovr_evt = wr_i && is_full && !pop_ok;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (flush_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            overrun_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - (AW+1)'(1);
            end
            // A new drop outranks a clear issued in the same cycle.
            if (ovr_evt) begin
                overrun_d = 1'b1;
            end else if (clr_ovr_i) begin
                overrun_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is deliberately not reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = is_empty ? '0 : mem_q[rd_ptr_q];
    assign empty_o   = is_empty;
    assign full_o    = is_full;
    assign count_o   = count_q;
    assign overrun_o = overrun_q;
    // Thresholds above DEPTH can never be reached, so the interrupt stays low for them.
    assign irq_o     = (thresh_i != '0) && (count_q >= thresh_i);

endmodule

// File: tb/tb_as_rx_fifo.sv
// Self-checking bench for as_rx_fifo: a queue model tracks accepted bytes and flags,
// popped bytes are compared against the queue head.
module tb_as_rx_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             wr_i;
    logic [WIDTH-1:0] wr_data_i;
    logic             rd_i;
    logic [WIDTH-1:0] rd_data_o;
    logic             flush_i;
    logic             clr_ovr_i;
    logic [AW:0]      thresh_i;
    logic             empty_o;
    logic             full_o;
    logic [AW:0]      count_o;
    logic             overrun_o;
    logic             irq_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] sb_q[$];
    bit               m_ovr = 1'b0;
    int               m_thr = 0;

    as_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_i      (wr_i),
        .wr_data_i (wr_data_i),
        .rd_i      (rd_i),
        .rd_data_o (rd_data_o),
        .flush_i   (flush_i),
        .clr_ovr_i (clr_ovr_i),
        .thresh_i  (thresh_i),
        .empty_o   (empty_o),
        .full_o    (full_o),
        .count_o   (count_o),
        .overrun_o (overrun_o),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = sb_q.size();
        check_val("count", 32'(count_o), 32'(sz));
        check_val("empty", 32'(empty_o), 32'(sz == 0));
        check_val("full", 32'(full_o), 32'(sz == DEPTH));
        check_val("overrun", 32'(overrun_o), 32'(m_ovr));
        check_val("irq", 32'(irq_o), 32'((m_thr != 0) && (sz >= m_thr)));
        check_val("head", 32'(rd_data_o), (sz > 0) ? 32'(sb_q[0]) : 32'h0);
    endtask

    task automatic set_thr(input int t);
        m_thr    = t;
        thresh_i = (AW+1)'(t);
        #1;
        check_state();
    endtask

    // One clock cycle of stimulus; the model follows the FIFO contract independently.
    task automatic cyc(input bit wr, input logic [WIDTH-1:0] d, input bit rd,
                       input bit fl = 1'b0, input bit co = 1'b0);
        int  sz;
        bit  pop_ok;
        bit  push_ok;
        sz        = sb_q.size();
        wr_i      = wr;
        wr_data_i = d;
        rd_i      = rd;
        flush_i   = fl;
        clr_ovr_i = co;
        pop_ok    = rd && (sz > 0) && !fl;
        if (pop_ok) check_val("pop_data", 32'(rd_data_o), 32'(sb_q[0]));
        @(posedge clk_i);
        #1;
        if (fl) begin
            sb_q.delete();
            m_ovr = 1'b0;
        end else begin
            push_ok = wr && ((sz < DEPTH) || pop_ok);
            if (pop_ok) void'(sb_q.pop_front());
            if (push_ok) sb_q.push_back(d);
            if (wr && !push_ok) m_ovr = 1'b1;
            else if (co) m_ovr = 1'b0;
        end
        wr_i      = 1'b0;
        rd_i      = 1'b0;
        flush_i   = 1'b0;
        clr_ovr_i = 1'b0;
        check_state();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #2;
        sb_q.delete();
        m_ovr = 1'b0;
        check_val("rst_count", 32'(count_o), 32'h0);
        check_val("rst_empty", 32'(empty_o), 32'h1);
        check_val("rst_full", 32'(full_o), 32'h0);
        check_val("rst_ovr", 32'(overrun_o), 32'h0);
        check_val("rst_irq", 32'(irq_o), 32'h0);
        check_val("rst_data", 32'(rd_data_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check_state();
    endtask

    initial begin
        rst_i = 1'b1; wr_i = 1'b0; wr_data_i = '0; rd_i = 1'b0;
        flush_i = 1'b0; clr_ovr_i = 1'b0; thresh_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        do_reset();

        // single byte round trip
        cyc(1, 8'h41, 0);
        check_val("t1_data", 32'(rd_data_o), 32'h41);
        cyc(0, 8'h00, 1);
        check_val("t1_empty", 32'(empty_o), 32'h1);

        // fill, then drain in order across the pointer wrap
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0);
        check_val("t2_full", 32'(full_o), 32'h1);
        for (int i = 0; i < DEPTH; i++) cyc(0, 8'h00, 1);

        // overrun while full, clear, drain; 0xAA must never appear
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'h10 + i), 0);
        cyc(1, 8'hAA, 0);
        check_val("t3_ovr", 32'(overrun_o), 32'h1);
        check_val("t3_head", 32'(rd_data_o), 32'h10);
        cyc(0, 8'h00, 0, 0, 1);
        cyc(1, 8'hAB, 0, 0, 1);
        check_val("t3_setwins", 32'(overrun_o), 32'h1);
        cyc(0, 8'h00, 0, 0, 1);
        // simultaneous push and pop at full: no overrun, 0x55 comes out last
        cyc(1, 8'h55, 1);
        check_val("t4_count", 32'(count_o), 32'(DEPTH));
        while (sb_q.size() > 0) cyc(0, 8'h00, 1);

        // pop when empty, then push+pop when empty
        cyc(0, 8'h00, 1);
        cyc(1, 8'h77, 1);
        check_val("t6_count", 32'(count_o), 32'h1);
        cyc(0, 8'h00, 1);

        // threshold interrupt
        set_thr(4);
        for (int i = 0; i < 3; i++) cyc(1, 8'(8'h30 + i), 0);
        check_val("t5_irq3", 32'(irq_o), 32'h0);
        cyc(1, 8'h33, 0);
        check_val("t5_irq4", 32'(irq_o), 32'h1);
        cyc(0, 8'h00, 1);
        check_val("t5_irqpop", 32'(irq_o), 32'h0);
        set_thr(0);
        set_thr(20);
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0);
        set_thr(16);
        set_thr(4);

        // leave 5 entries with overrun set, then flush with a push in flight
        cyc(1, 8'hEE, 0);
        while (sb_q.size() > 5) cyc(0, 8'h00, 1);
        check_val("t7_ovrset", 32'(overrun_o), 32'h1);
        cyc(1, 8'h99, 1, 1);
        check_val("t7_flush", 32'(count_o), 32'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
        end

        // reset mid-stream
        for (int i = 0; i < 6; i++) cyc(1, 8'(8'hC0 + i), 0);
        wr_i = 1'b1;
        wr_data_i = 8'hDD;
        do_reset();
        wr_i = 1'b0;
        cyc(1, 8'h12, 0);
        cyc(0, 8'h00, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
